sram_arbiter: RTL

//  Registered, round-robin arbiter sharing the single 1536-bit frame SRAM port between fill (req 0) and alpha-blend (req 1).

---
 rtl/gpu_sram_pkg.sv | 31 +++
 rtl/sram_rd_tag_pipe.sv | 31 +++
 rtl/sram_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/gpu_sram_pkg.sv
// Shared types and helpers for the frame SRAM arbiter.
package gpu_sram_pkg;

  localparam int SRAM_ADDR_W = 24;
  localparam int SRAM_DATA_W = 1536;

  typedef logic [SRAM_ADDR_W-1:0] addr_t;
  typedef logic [SRAM_DATA_W-1:0] data_t;

  typedef enum logic {
    REQ_FILL  = 1'b0,
    REQ_ALPHA = 1'b1
  } req_id_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // Requester id -> one-hot grant/valid vector.
  function automatic logic [1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

  // 32-bit counter increment that sticks at all-ones.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sram_rd_tag_pipe.sv
// Read-return tag pipeline. Each stage carries a one-hot requester tag
// (all-zero = empty), so the last stage is directly the registered rvalid.
// A tag pushed in the grant cycle N appears on o_rvalid in N+1+READ_LAT.
module sram_rd_tag_pipe #(
  parameter int READ_LAT = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] i_tag,
  output logic [1:0] o_rvalid,
  output logic       o_busy
);

  logic [READ_LAT:0][1:0] r_vld_pipe;

  // Shift tags toward the return stage; reset drops anything in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= i_tag;
      for (int k = 1; k <= READ_LAT; k++) begin
        r_vld_pipe[k] <= r_vld_pipe[k-1];
      end
    end
  end

  assign o_rvalid = r_vld_pipe[READ_LAT];
  assign o_busy   = |r_vld_pipe;

endmodule

// File: rtl/sram_arbiter.sv
// Registered round-robin arbiter for the shared frame SRAM port.
// Requester 0 = fill, requester 1 = alpha blend. Locked owners keep the port
// across a read-modify-write, but are forced off after MAX_BURST grants when
// the other side is waiting. Read returns are tagged back to the issuer.
// Optional build macro SRAM_ARB_STATS_EN adds grant/stall counters.
module sram_arbiter
  import gpu_sram_pkg::*;
#(
  parameter int ADDR_W    = SRAM_ADDR_W,
  parameter int DATA_W    = SRAM_DATA_W,
  parameter int READ_LAT  = 2,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [1:0]        req,
  input  logic [1:0]        lock,
  input  logic [1:0]        wr,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic              busy,
  output logic              read_enable,
  output logic              write_enable,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [31:0]       gnt_cnt0,
  output logic [31:0]       gnt_cnt1,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int BC_W = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
  localparam logic [BC_W-1:0] BURST_LAST = BC_W'(MAX_BURST - 1);

  arb_state_e      r_state, w_state_nxt;
  logic [BC_W-1:0] r_burst_cnt, w_burst_nxt;
  logic            r_last;
  logic            w_gid;
  logic            w_own;
  logic [1:0]      w_gnt;
  logic [1:0]      w_wr_eff;
  logic            w_wr_go;
  logic            w_rd_go;
  logic [1:0]      w_rd_tag;
  logic            w_pipe_busy;

  logic              r_re;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  // Alpha never writes: its wr bit is masked so such a command issues as a read.
  assign w_wr_eff = wr & 2'b01;

  // Next-state, grant and burst accounting.
  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = r_burst_cnt;
    w_gnt       = 2'b00;
    w_gid       = 1'b0;
    w_own       = (r_state == OWN1);
    unique case (r_state)
      IDLE: begin
        if (|req) begin
          // On a tie the side that did not win last time goes.
          w_gid = (&req) ? ~r_last : req[1];
          w_gnt = id_onehot(w_gid);
          if (lock[w_gid]) begin
            w_state_nxt = w_gid ? OWN1 : OWN0;
            w_burst_nxt = BC_W'(1);
          end
        end
      end
      OWN0, OWN1: begin
        w_gid = w_own;
        if (req[w_own]) begin
          w_gnt = id_onehot(w_own);
          if (r_burst_cnt < BURST_LAST) begin
            w_burst_nxt = r_burst_cnt + BC_W'(1);
          end
        end
        // Owner without req but still locked keeps the port (RMW gap).
        if (!lock[w_own] ||
            (req[w_own] && (r_burst_cnt == BURST_LAST) && req[~w_own])) begin
          w_state_nxt = IDLE;
          w_burst_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_burst_nxt = '0;
      end
    endcase
  end

  assign w_wr_go  = (|w_gnt) && w_wr_eff[w_gid];
  assign w_rd_go  = (|w_gnt) && !w_wr_eff[w_gid];
  assign w_rd_tag = w_rd_go ? id_onehot(w_gid) : 2'b00;

  // Arbitration state, burst count and round-robin pointer.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_burst_cnt <= '0;
      r_last      <= REQ_ALPHA;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_nxt;
      if (|w_gnt) r_last <= w_gid;
    end
  end

  // Registered SRAM command; strobes are single-cycle, address/data hold.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_re    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_re <= w_rd_go;
      r_we <= w_wr_go;
      if (|w_gnt) begin
        r_addr <= w_gid ? addr1 : addr0;
        if (w_gid == REQ_FILL) r_wdata <= wdata0;
      end
    end
  end

  sram_rd_tag_pipe #(
    .READ_LAT (READ_LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .n_rst    (n_rst),
    .i_tag    (w_rd_tag),
    .o_rvalid (rvalid),
    .o_busy   (w_pipe_busy)
  );

  assign gnt          = w_gnt;
  assign busy         = w_pipe_busy | r_re | r_we;
  assign read_enable  = r_re;
  assign write_enable = r_we;
  assign address      = r_addr;
  assign write_data   = r_wdata;

`ifdef SRAM_ARB_STATS_EN
  logic [31:0] r_gnt_cnt0;
  logic [31:0] r_gnt_cnt1;
  logic [31:0] r_stall_cnt;

  // Saturating grant counters and stall counter (request pending, no grant).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_gnt_cnt0  <= '0;
      r_gnt_cnt1  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_gnt[0]) r_gnt_cnt0 <= sat_inc32(r_gnt_cnt0);
      if (w_gnt[1]) r_gnt_cnt1 <= sat_inc32(r_gnt_cnt1);
      if ((|req) && !(|w_gnt)) r_stall_cnt <= sat_inc32(r_stall_cnt);
    end
  end

  assign gnt_cnt0  = r_gnt_cnt0;
  assign gnt_cnt1  = r_gnt_cnt1;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule
